// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the MIPS fetch/next-PC slice.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   // Fetch sequencing: request, wait on data memory with a buffered word, frozen.
   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      HOLD   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam word_t WORD_BYTES = 32'd4;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory port plus next-PC selector port of the fetch unit.
interface pc_fetch_unit_if;
   import cpu_types_pkg::*;

   logic  ihit;
   word_t imemload;
   logic  imemREN;
   word_t imemaddr;
   word_t next_PC;
   word_t PC4;
   word_t BranchAddr;
   word_t JumpAddr;
   logic  stall;

   // Fetch unit side: owns the PC, issues reads, offers branch/jump targets.
   modport master (
      input  ihit, imemload, next_PC,
      output imemREN, imemaddr, PC4, BranchAddr, JumpAddr, stall
   );

   // Memory control and next-PC selector side.
   modport slave (
      output ihit, imemload, next_PC,
      input  imemREN, imemaddr, PC4, BranchAddr, JumpAddr, stall
   );

endinterface

// File: rtl/branch_target_calc.sv
// Branch and jump target generation from PC+4 and the current instruction.
module branch_target_calc
   import cpu_types_pkg::*;
(
   input  word_t PC4,
   input  word_t instr,
   output word_t BranchAddr,
   output word_t JumpAddr
);

   // The opcode field plays no part in target arithmetic.
   logic unused_opcode;

   // Sign-extended word offset added modulo 2^32; jump keeps the PC4 region.
   always_comb begin
      unused_opcode = ^instr[31:26];
      BranchAddr    = PC4 + {{14{instr[15]}}, instr[15:0], 2'b00};
      JumpAddr      = {PC4[31:28], instr[25:0], 2'b00};
   end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter owner: sequences instruction reads, buffers a fetched word
// while data memory stalls, commits next_PC on an advance, freezes on halt.
module pc_fetch_unit
   import cpu_types_pkg::*;
#(
   parameter word_t PC_INIT = 32'h0000_0000,
   parameter int    CNT_W   = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   pc_fetch_unit_if.master  bus,
   input  logic             dstall,
   input  logic             halt,
   output word_t            PC,
   output word_t            instr,
   output logic             instr_valid,
   output logic             halted,
   output logic [CNT_W-1:0] retired
);

   fetch_state_t     state_q, state_d;
   word_t            pc_q, pc_d;
   word_t            instr_buf_q, instr_buf_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             advance;

   // State register; every architectural flop is cleared by the async reset.
   // NOTE: sequential state uses non-blocking assignments so all flops see the
   // pre-edge values of each other, regardless of statement order.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q     <= FETCH;
         pc_q        <= PC_INIT;
         instr_buf_q <= '0;
         retired_q   <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         instr_buf_q <= instr_buf_d;
         retired_q   <= retired_d;
      end
   end

   // Next-state, PC commit and handshake outputs for each fetch state.
   // NOTE: every signal written here gets a default first so no path leaves a
   // value unassigned and no latch is inferred.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_buf_d   = instr_buf_q;
      retired_d     = retired_q;
      advance       = 1'b0;
      bus.imemREN   = 1'b0;
      instr         = instr_buf_q;
      instr_valid   = 1'b0;
      halted        = 1'b0;

      case (state_q)
         FETCH: begin
            bus.imemREN = 1'b1;
            instr       = bus.imemload;
            // NOTE: outputs are gated with nRST so that while reset is held the
            // unit reports no valid instruction and a stalled PC.
            instr_valid = bus.ihit & nRST;
            advance     = bus.ihit & ~dstall & ~halt & nRST;
            if (bus.ihit) begin
               if (halt) begin
                  state_d = HALTED;
               end else if (dstall) begin
                  instr_buf_d = bus.imemload;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            instr_valid = 1'b1;
            advance     = ~dstall & ~halt;
            if (halt) begin
               state_d = HALTED;
            end else if (!dstall) begin
               state_d = FETCH;
            end
         end
         default: begin
            halted = 1'b1;
         end
      endcase

      if (advance) begin
         pc_d      = bus.next_PC;
         retired_d = retired_q + CNT_W'(1);
      end
      bus.stall = ~advance;
   end

   // PC-derived outputs.
   always_comb begin
      PC           = pc_q;
      bus.imemaddr = pc_q;
      bus.PC4      = pc_q + WORD_BYTES;
      retired      = retired_q;
   end

   branch_target_calc u_targets (
      .PC4        (bus.PC4),
      .instr      (instr),
      .BranchAddr (bus.BranchAddr),
      .JumpAddr   (bus.JumpAddr)
   );

endmodule
